// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: multi-digit BCD stopwatch with an internal tick prescaler,
// a start/stop/clear run-state machine, lap capture and an overflow policy
// selected by WRAP: saturate and hold, or roll over and keep counting.
// Every output is registered.
module bcd_stopwatch #(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 100000,
    parameter int WRAP     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   lap_value,
    output logic                  lap_valid,
    output logic                  running,
    output logic                  ovf
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic          WRAP_EN = (WRAP != 0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUNNING   = 2'd1,
        ST_PAUSED    = 2'd2,
        ST_SATURATED = 2'd3
    } state_t;

    // Adds one to a packed BCD value. A digit at 9 goes to 0 and passes the
    // carry upward. An all-9s input comes back as all-0s.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] res;
        logic         carry;
        res   = v;
        carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (v[4*k +: 4] == 4'd9) begin
                    res[4*k +: 4] = 4'd0;
                end else begin
                    res[4*k +: 4] = v[4*k +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[4*k +: 4] = v[4*k +: 4];
            end
        end
        return res;
    endfunction

    // True when every digit holds 9, the value at which the next tick overflows.
    function automatic logic is_all_nines(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            ok = ok & (v[4*k +: 4] == 4'd9);
        end
        return ok;
    endfunction

    state_t          state_r, state_next_s;
    logic [PW-1:0]   prescale_r, prescale_next_s;
    logic [W-1:0]    count_r, count_next_s;
    logic [W-1:0]    lap_value_r, lap_value_next_s;
    logic            lap_valid_r, lap_valid_next_s;
    logic            ovf_r, ovf_next_s;
    logic            running_r;
    logic            tick_s;
    logic            top_s;

    assign tick_s = (state_r == ST_RUNNING) && (prescale_r == PS_LAST);
    assign top_s  = is_all_nines(count_r);

    // Next-state, prescaler, count, lap and overflow logic; clear has top priority.
    always_comb begin
        state_next_s     = state_r;
        prescale_next_s  = prescale_r;
        count_next_s     = count_r;
        lap_value_next_s = lap_value_r;
        lap_valid_next_s = 1'b0;
        // The pulse form of ovf drops back to 0 on its own. The sticky form holds.
        ovf_next_s       = WRAP_EN ? 1'b0 : ovf_r;

        if (clear) begin
            state_next_s     = ST_IDLE;
            prescale_next_s  = {PW{1'b0}};
            count_next_s     = {W{1'b0}};
            lap_value_next_s = {W{1'b0}};
            ovf_next_s       = 1'b0;
        end else begin
            // The prescaler advances only while running. It holds its value
            // otherwise, so a resume keeps the tick phase.
            if (state_r == ST_RUNNING) begin
                if (tick_s) begin
                    prescale_next_s = {PW{1'b0}};
                    ovf_next_s      = top_s ? 1'b1 : ovf_next_s;
                    if (top_s && !WRAP_EN) begin
                        count_next_s = count_r;
                    end else begin
                        count_next_s = bcd_inc(count_r);
                    end
                end else begin
                    prescale_next_s = prescale_r + PW'(1'b1);
                end
            end else begin
                prescale_next_s = prescale_r;
            end

            // The lap value is the count as it stood before this edge's increment.
            if (lap && (state_r != ST_IDLE)) begin
                lap_value_next_s = count_r;
                lap_valid_next_s = 1'b1;
            end else begin
                lap_valid_next_s = 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_RUNNING;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUNNING: begin
                    // If saturation and stop arrive on the same edge, saturation wins.
                    if (tick_s && top_s && !WRAP_EN) begin
                        state_next_s = ST_SATURATED;
                    end else if (stop) begin
                        state_next_s = ST_PAUSED;
                    end else begin
                        state_next_s = ST_RUNNING;
                    end
                end
                ST_PAUSED: begin
                    if (start && !stop) begin
                        state_next_s = ST_RUNNING;
                    end else begin
                        state_next_s = ST_PAUSED;
                    end
                end
                ST_SATURATED: begin
                    state_next_s = ST_SATURATED;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            prescale_r  <= {PW{1'b0}};
            count_r     <= {W{1'b0}};
            lap_value_r <= {W{1'b0}};
            lap_valid_r <= 1'b0;
            ovf_r       <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            prescale_r  <= prescale_next_s;
            count_r     <= count_next_s;
            lap_value_r <= lap_value_next_s;
            lap_valid_r <= lap_valid_next_s;
            ovf_r       <= ovf_next_s;
            running_r   <= (state_next_s == ST_RUNNING);
        end
    end

    assign count     = count_r;
    assign lap_value = lap_value_r;
    assign lap_valid = lap_valid_r;
    assign running   = running_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch: directed self-checking bench for bcd_stopwatch. It runs
// four instances with different parameter sets. They share one set of
// control inputs, and each scenario checks only the instance it targets.
module tb_bcd_stopwatch;

    logic clk = 1'b0;
    logic rst, start, stop, clear, lap;

    logic [11:0] c_a, lv_a;  logic lvd_a, run_a, ovf_a;   // DIGITS=3 PRESCALE=4
    logic [11:0] c_b, lv_b;  logic lvd_b, run_b, ovf_b;   // DIGITS=3 PRESCALE=1
    logic [7:0]  c_s, lv_s;  logic lvd_s, run_s, ovf_s;   // DIGITS=2 saturate
    logic [7:0]  c_w, lv_w;  logic lvd_w, run_w, ovf_w;   // DIGITS=2 wrap

    int checks = 0;
    int errors = 0;

    bcd_stopwatch #(.DIGITS(3), .PRESCALE(4), .WRAP(0)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(c_a), .lap_value(lv_a), .lap_valid(lvd_a), .running(run_a), .ovf(ovf_a));
    bcd_stopwatch #(.DIGITS(3), .PRESCALE(1), .WRAP(0)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(c_b), .lap_value(lv_b), .lap_valid(lvd_b), .running(run_b), .ovf(ovf_b));
    bcd_stopwatch #(.DIGITS(2), .PRESCALE(1), .WRAP(0)) u_s (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(c_s), .lap_value(lv_s), .lap_valid(lvd_s), .running(run_s), .ovf(ovf_s));
    bcd_stopwatch #(.DIGITS(2), .PRESCALE(1), .WRAP(1)) u_w (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .count(c_w), .lap_value(lv_w), .lap_valid(lvd_w), .running(run_w), .ovf(ovf_w));

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) step();
        checks++; if (c_a !== 12'h000) begin errors++; $display("FAIL reset_count got %h want 000", c_a); end
        checks++; if ({run_a, ovf_a, lvd_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {run_a, ovf_a, lvd_a}); end
        // rst beats start
        rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL reset_over_start got %b want 0", run_a); end
    endtask

    task automatic test_basic_count();
        do_reset();
        pulse_start();   // edge N
        checks++; if ({run_a, c_a} !== {1'b1, 12'h000}) begin errors++; $display("FAIL start_edge got %b/%h want 1/000", run_a, c_a); end
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 3) begin
                checks++; if (c_a !== 12'h000) begin errors++; $display("FAIL pre_first_tick got %h want 000", c_a); end
            end
            if (i == 4) begin
                checks++; if (c_a !== 12'h001) begin errors++; $display("FAIL first_tick got %h want 001", c_a); end
            end
            if (i == 39) begin
                checks++; if (c_a !== 12'h009) begin errors++; $display("FAIL before_carry got %h want 009", c_a); end
            end
        end
        checks++; if (c_a !== 12'h010) begin errors++; $display("FAIL carry_009_010 got %h want 010", c_a); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        pulse_start();                      // N: prescaler 0
        for (int i = 0; i < 5; i++) step(); // N+5: count 1, prescaler 1
        stop = 1'b1; step(); stop = 1'b0;   // N+6: prescaler 2, paused
        checks++; if ({run_a, c_a} !== {1'b0, 12'h001}) begin errors++; $display("FAIL stop got %b/%h want 0/001", run_a, c_a); end
        for (int i = 0; i < 10; i++) step();
        checks++; if ({run_a, c_a} !== {1'b0, 12'h001}) begin errors++; $display("FAIL paused_hold got %b/%h want 0/001", run_a, c_a); end
        pulse_start();                      // M
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL resume got %b want 1", run_a); end
        step();                             // M+1
        checks++; if (c_a !== 12'h001) begin errors++; $display("FAIL resume_m1 got %h want 001", c_a); end
        step();                             // M+2
        checks++; if (c_a !== 12'h002) begin errors++; $display("FAIL resume_m2 got %h want 002", c_a); end
    endtask

    task automatic test_lap();
        do_reset();
        pulse_start();
        for (int i = 0; i < 47; i++) step();
        checks++; if (c_b !== 12'h047) begin errors++; $display("FAIL lap_pre got %h want 047", c_b); end
        lap = 1'b1; step(); lap = 1'b0;
        checks++; if ({lvd_b, lv_b, c_b} !== {1'b1, 12'h047, 12'h048}) begin errors++; $display("FAIL lap_capture got %b/%h/%h want 1/047/048", lvd_b, lv_b, c_b); end
        step();
        checks++; if ({lvd_b, c_b} !== {1'b0, 12'h049}) begin errors++; $display("FAIL lap_pulse_end got %b/%h want 0/049", lvd_b, c_b); end
        lap = 1'b1; clear = 1'b1; step(); lap = 1'b0; clear = 1'b0;
        checks++; if ({lvd_b, run_b, c_b, lv_b} !== {2'b00, 12'h000, 12'h000}) begin errors++; $display("FAIL lap_clear got %b%b/%h/%h want 00/000/000", lvd_b, run_b, c_b, lv_b); end
        lap = 1'b1; step(); lap = 1'b0;
        checks++; if (lvd_b !== 1'b0) begin errors++; $display("FAIL lap_idle got %b want 0", lvd_b); end
    endtask

    task automatic test_saturate();
        do_reset();
        pulse_start();
        for (int i = 0; i < 99; i++) step();
        checks++; if ({c_s, ovf_s, run_s} !== {8'h99, 2'b01}) begin errors++; $display("FAIL sat_pre got %h/%b/%b want 99/0/1", c_s, ovf_s, run_s); end
        step();
        checks++; if ({c_s, ovf_s, run_s} !== {8'h99, 2'b10}) begin errors++; $display("FAIL sat got %h/%b/%b want 99/1/0", c_s, ovf_s, run_s); end
        pulse_start();
        checks++; if ({c_s, ovf_s, run_s} !== {8'h99, 2'b10}) begin errors++; $display("FAIL sat_start got %h/%b/%b want 99/1/0", c_s, ovf_s, run_s); end
        clear = 1'b1; step(); clear = 1'b0;
        checks++; if ({c_s, ovf_s, run_s} !== {8'h00, 2'b00}) begin errors++; $display("FAIL sat_clear got %h/%b/%b want 00/0/0", c_s, ovf_s, run_s); end
        pulse_start();
        checks++; if (run_s !== 1'b1) begin errors++; $display("FAIL sat_restart got %b want 1", run_s); end
    endtask

    task automatic test_wrap();
        do_reset();
        pulse_start();
        for (int i = 0; i < 99; i++) step();
        checks++; if ({c_w, ovf_w} !== {8'h99, 1'b0}) begin errors++; $display("FAIL wrap_pre got %h/%b want 99/0", c_w, ovf_w); end
        step();
        checks++; if ({c_w, ovf_w, run_w} !== {8'h00, 2'b11}) begin errors++; $display("FAIL wrap got %h/%b/%b want 00/1/1", c_w, ovf_w, run_w); end
        step();
        checks++; if ({c_w, ovf_w} !== {8'h01, 1'b0}) begin errors++; $display("FAIL wrap_ovf_pulse got %h/%b want 01/0", c_w, ovf_w); end
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        checks++; if ({c_w, run_w} !== {8'h02, 1'b0}) begin errors++; $display("FAIL stop_beats_start got %h/%b want 02/0", c_w, run_w); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (c_w !== 8'h02) begin errors++; $display("FAIL wrap_paused got %h want 02", c_w); end
        lap = 1'b1; step(); lap = 1'b0;
        checks++; if ({lvd_w, lv_w} !== {1'b1, 8'h02}) begin errors++; $display("FAIL paused_lap got %b/%h want 1/02", lvd_w, lv_w); end
        pulse_start();
        step();
        checks++; if (c_w !== 8'h03) begin errors++; $display("FAIL wrap_resume got %h want 03", c_w); end
        lap = 1'b1; step(); lap = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        checks++; if ({c_w, lv_w, lvd_w, run_w, ovf_w} !== {8'h00, 8'h00, 3'b000}) begin errors++; $display("FAIL midrun_reset got %h/%h/%b%b%b want 00/00/000", c_w, lv_w, lvd_w, run_w, ovf_w); end
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_lap();
        test_saturate();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
